vc_arbiter: RTL

VC_ARBITER -- requirements
Module: vc_arbiter

---
 rtl/vc_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vc_arbiter.sv
// Virtual-channel arbiter: pops one word per clock from four input FIFOs and
// steers it to the output FIFO named by the word's top two bits.
// Optional build macro VC_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module vc_arbiter #(
  parameter int BW = 6,
  parameter int NQ = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [NQ-1:0] in_empty,
  input  logic [BW-1:0] in_data0,
  input  logic [BW-1:0] in_data1,
  input  logic [BW-1:0] in_data2,
  input  logic [BW-1:0] in_data3,
  input  logic [NQ-1:0] out_almost_full,
  output logic [NQ-1:0] pop,
  output logic [NQ-1:0] push,
  output logic [BW-1:0] data_out,
  output logic          idle
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [NQ-1:0] r_push;
  logic [BW-1:0] r_data_out;
  logic          r_idle;

  logic          w_stall;
  logic          w_any;
  logic [NQ-1:0] w_req;
  logic [NQ-1:0] w_grant;
  logic [1:0]    w_gidx;
  logic [1:0]    w_cand;
  logic [1:0]    w_dest;
  logic [BW-1:0] w_sel_data;
  logic [NQ-1:0] w_push_nxt;

`ifdef VC_ARB_ROUND_ROBIN_EN
  logic [1:0]    r_ptr;
`endif

  // Any downstream almost-full blocks every input; the in-flight word still lands.
  assign w_stall = |out_almost_full;
  assign w_req   = ((r_state != ST_INIT) && !w_stall) ? ~in_empty : '0;

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef VC_ARB_ROUND_ROBIN_EN
      w_cand = r_ptr + 2'(k + 1);
`else
      w_cand = 2'(k);
`endif
      if (!w_any && w_req[w_cand]) begin
        w_any           = 1'b1;
        w_gidx          = w_cand;
        w_grant[w_cand] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = in_data0;
    case (w_gidx)
      2'd0:    w_sel_data = in_data0;
      2'd1:    w_sel_data = in_data1;
      2'd2:    w_sel_data = in_data2;
      default: w_sel_data = in_data3;
    endcase
  end

  assign w_dest = w_sel_data[BW-1:BW-2];

  always_comb begin
    w_push_nxt = '0;
    if (w_any) begin
      w_push_nxt[w_dest] = 1'b1;
    end
  end

  // INIT never grants, so it always falls through to IDLE after one clock.
  assign w_state_nxt = w_any ? ST_ACTIVE : ST_IDLE;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_INIT;
      r_push     <= '0;
      r_data_out <= '0;
      r_idle     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_push_nxt;
      r_idle  <= !w_any;
      if (w_any) begin
        r_data_out <= w_sel_data;
      end
    end
  end

`ifdef VC_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr <= 2'd3;
    end else if (w_any) begin
      r_ptr <= w_gidx;
    end
  end
`endif

  assign pop      = w_grant;
  assign push     = r_push;
  assign data_out = r_data_out;
  assign idle     = r_idle;

`ifndef SYNTHESIS
  a_pop_onehot: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(pop));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!reset_L) (pop & in_empty) == '0);
  a_push_onehot: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(push));
`endif

endmodule
